// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encodings, default bit
// timing and the layout of a receive FIFO entry.
package uart_pkg;

  localparam int CLKS_PER_BIT = 217;

  localparam int PE_BIT  = 9;
  localparam int FE_BIT  = 8;
  localparam int ENTRY_W = 10;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP      = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

  typedef struct packed {
    logic       pe;
    logic       fe;
    logic [7:0] data;
  } rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-side handshake of the UART receiver: head byte, its error flags,
// valid and ready.
interface uart_rx_fifo_if;

  logic [7:0] rx_data_out;
  logic       rx_dv;
  logic       rx_ready;
  logic       rx_frame_err;
  logic       rx_parity_err;

  modport master (
    output rx_data_out,
    output rx_dv,
    output rx_frame_err,
    output rx_parity_err,
    input  rx_ready
  );

  modport slave (
    input  rx_data_out,
    input  rx_dv,
    input  rx_frame_err,
    input  rx_parity_err,
    output rx_ready
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous register FIFO with push/pop, full/empty and occupancy count.
// A push while full is ignored unless a pop happens in the same clock.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage resets to zero so the head reads 0 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver (8 data bits, optional parity, 1 stop bit) with
// glitch rejection, framing/parity/break detection and a receive FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int cpb        = CLKS_PER_BIT,
  parameter bit parity_en  = 1'b0,
  parameter bit parity_odd = 1'b0,
  parameter int fifo_depth = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx_data_in,
  uart_rx_fifo_if.master rx_if,
  output logic           rx_overrun,
  output logic           rx_break,
  output logic           rx_busy
);

  localparam int CW = $clog2(cpb);
  localparam logic [CW-1:0] CNT_LAST = CW'(cpb - 1);
  localparam logic [CW-1:0] CNT_S0   = CW'(cpb / 2 - 1);
  localparam logic [CW-1:0] CNT_S1   = CW'(cpb / 2);
  localparam logic [CW-1:0] CNT_S2   = CW'(cpb / 2 + 1);

  logic [1:0]    sync_q;
  logic [1:0]    vld_q;
  logic          line_hi_q;
  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shreg_q, shreg_d;
  logic [1:0]    smp_q, smp_d;
  logic          pe_q, pe_d;
  logic          par_q, par_d;
  logic          break_q, overrun_q;
  logic          brk, push, maj, at_mid, rx_s;
  rx_entry_t     push_entry;
  logic [ENTRY_W-1:0] head;
  logic          fifo_full, fifo_empty;

  assign rx_s   = sync_q[1];
  assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);
  assign at_mid = (cnt_q == CNT_S2);

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_d      = bit_q;
    shreg_d    = shreg_q;
    smp_d      = smp_q;
    pe_d       = pe_q;
    par_d      = par_q;
    push       = 1'b0;
    brk        = 1'b0;
    push_entry = '0;
    if (cnt_q == CNT_S0) smp_d[0] = rx_s;
    if (cnt_q == CNT_S1) smp_d[1] = rx_s;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (line_hi_q && !rx_s) state_d = ST_START;
      end
      ST_START: begin
        if (at_mid && maj) state_d = ST_IDLE;
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_DATA;
          bit_d   = '0;
          pe_d    = 1'b0;
          par_d   = 1'b0;
        end
      end
      ST_DATA: begin
        if (at_mid) shreg_d = {maj, shreg_q[7:1]};
        if (cnt_q == CNT_LAST) begin
          if (bit_q == 3'd7) state_d = parity_en ? ST_PARITY : ST_STOP;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      ST_PARITY: begin
        if (at_mid) begin
          par_d = maj;
          pe_d  = ((^shreg_q) ^ parity_odd) != maj;
        end
        if (cnt_q == CNT_LAST) state_d = ST_STOP;
      end
      ST_STOP: begin
        // A good stop bit frees the FSM at mid-bit so back-to-back frames resync.
        if (at_mid) begin
          if (maj) begin
            push       = 1'b1;
            push_entry = '{pe: pe_q, fe: 1'b0, data: shreg_q};
            state_d    = ST_IDLE;
          end else if (shreg_q == 8'h00 && (!parity_en || !par_q)) begin
            brk     = 1'b1;
            state_d = ST_WAIT_IDLE;
          end else begin
            push       = 1'b1;
            push_entry = '{pe: pe_q, fe: 1'b1, data: shreg_q};
            state_d    = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // line_hi_q only trusts the synchronizer once real line samples have
  // replaced its reset value, so a line held low through reset never starts a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      vld_q     <= 2'b00;
      line_hi_q <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shreg_q   <= '0;
      smp_q     <= '0;
      pe_q      <= 1'b0;
      par_q     <= 1'b0;
      break_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx_data_in};
      vld_q     <= {vld_q[0], 1'b1};
      line_hi_q <= vld_q[1] & rx_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shreg_q   <= shreg_d;
      smp_q     <= smp_d;
      pe_q      <= pe_d;
      par_q     <= par_d;
      break_q   <= brk;
      overrun_q <= push && fifo_full && !rx_if.rx_ready;
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (rx_if.rx_ready),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o ()
  );

  assign rx_if.rx_dv         = !fifo_empty;
  assign rx_if.rx_data_out   = head[7:0];
  assign rx_if.rx_frame_err  = head[FE_BIT];
  assign rx_if.rx_parity_err = head[PE_BIT];
  assign rx_overrun          = overrun_q;
  assign rx_break            = break_q;
  assign rx_busy             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: one default instance and one odd-parity
// instance, driven bit by bit with hand-computed expected entries.
module tb_uart_rx_fifo;

  localparam int CPB = 217;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line0 = 1'b1;
  logic line1 = 1'b1;
  logic ovr0, brk0, busy0, ovr1, brk1, busy1;

  int checks = 0;
  int errors = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  int dvCycles0 = 0;
  int ovrCount0 = 0;
  int brkCount0 = 0;

  uart_rx_fifo_if if0 ();
  uart_rx_fifo_if if1 ();

  uart_rx_fifo dut0 (
    .clk        (clk),
    .rst        (rst),
    .rx_data_in (line0),
    .rx_if      (if0),
    .rx_overrun (ovr0),
    .rx_break   (brk0),
    .rx_busy    (busy0)
  );

  uart_rx_fifo #(
    .parity_en  (1'b1),
    .parity_odd (1'b1)
  ) dut1 (
    .clk        (clk),
    .rst        (rst),
    .rx_data_in (line1),
    .rx_if      (if1),
    .rx_overrun (ovr1),
    .rx_break   (brk1),
    .rx_busy    (busy1)
  );

  always #5 clk = ~clk;

  // Record every handshake and pulse just after the falling edge.
  always @(negedge clk) begin
    #1;
    if (if0.rx_dv) dvCycles0++;
    if (ovr0) ovrCount0++;
    if (brk0) brkCount0++;
    if (if0.rx_dv && if0.rx_ready)
      q0.push_back({if0.rx_parity_err, if0.rx_frame_err, if0.rx_data_out});
    if (if1.rx_dv && if1.rx_ready)
      q1.push_back({if1.rx_parity_err, if1.rx_frame_err, if1.rx_data_out});
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearMonitors();
    q0.delete();
    q1.delete();
    dvCycles0 = 0;
    ovrCount0 = 0;
    brkCount0 = 0;
  endtask

  task automatic driveBit(input int sel, input logic v);
    if (sel == 0) line0 = v;
    else          line1 = v;
    repeat (CPB) @(negedge clk);
  endtask

  // Leaves the line at the stop-bit level when it returns.
  task automatic applyStimulus(input int sel, input logic [7:0] data, input bit hasPar,
                               input bit parBit, input bit stopBit);
    driveBit(sel, 1'b0);
    for (int i = 0; i < 8; i++) driveBit(sel, data[i]);
    if (hasPar) driveBit(sel, parBit);
    driveBit(sel, stopBit);
  endtask

  function automatic logic [9:0] entryAt(input int sel, input int idx);
    if (sel == 0) begin
      if (idx < q0.size()) return q0[idx];
    end else begin
      if (idx < q1.size()) return q1[idx];
    end
    return 'x;
  endfunction

  initial begin
    if0.rx_ready = 1'b1;
    if1.rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset_outputs0",
                {if0.rx_dv, if0.rx_data_out, if0.rx_frame_err, if0.rx_parity_err, ovr0, brk0, busy0}, 0);
    checkOutput("reset_outputs1",
                {if1.rx_dv, if1.rx_data_out, if1.rx_frame_err, if1.rx_parity_err, ovr1, brk1, busy1}, 0);
    repeat (10) @(negedge clk);

    $display("[TB] basic byte 0x69");
    clearMonitors();
    applyStimulus(0, 8'h69, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t1_count", q0.size(), 1);
    checkOutput("t1_entry", entryAt(0, 0), 10'h069);
    checkOutput("t1_dv_width", dvCycles0, 1);

    $display("[TB] odd parity 0xA5");
    clearMonitors();
    applyStimulus(1, 8'hA5, 1'b1, 1'b1, 1'b1);
    applyStimulus(1, 8'hA5, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t2_count", q1.size(), 2);
    checkOutput("t2_good_parity", entryAt(1, 0), 10'h0A5);
    checkOutput("t2_bad_parity", entryAt(1, 1), 10'h2A5);

    $display("[TB] start-bit glitch");
    clearMonitors();
    line0 = 1'b0;
    repeat (30) @(negedge clk);
    checkOutput("t3_busy_in_glitch", busy0, 1);
    repeat (30) @(negedge clk);
    line0 = 1'b1;
    repeat (CPB - 60) @(negedge clk);
    checkOutput("t3_busy_after", busy0, 0);
    checkOutput("t3_no_dv", dvCycles0, 0);
    repeat (10) @(negedge clk);
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t3_count", q0.size(), 1);
    checkOutput("t3_entry", entryAt(0, 0), 10'h03C);

    $display("[TB] framing error");
    clearMonitors();
    applyStimulus(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    repeat (50) @(negedge clk);
    checkOutput("t4_wait_idle_busy", busy0, 1);
    checkOutput("t4_entry", entryAt(0, 0), 10'h13C);
    line0 = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t4_idle_after_rise", busy0, 0);
    clearMonitors();
    applyStimulus(0, 8'h55, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t4_clean_count", q0.size(), 1);
    checkOutput("t4_clean_entry", entryAt(0, 0), 10'h055);

    $display("[TB] overrun");
    if0.rx_ready = 1'b0;
    clearMonitors();
    for (int b = 1; b <= 4; b++) applyStimulus(0, 8'(b), 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t5_no_overrun_yet", ovrCount0, 0);
    applyStimulus(0, 8'h05, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t5_overrun_once", ovrCount0, 1);
    checkOutput("t5_head_valid", {if0.rx_dv, if0.rx_data_out}, 9'h101);
    if0.rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    checkOutput("t5_drain_count", q0.size(), 4);
    checkOutput("t5_drain0", entryAt(0, 0), 10'h001);
    checkOutput("t5_drain1", entryAt(0, 1), 10'h002);
    checkOutput("t5_drain2", entryAt(0, 2), 10'h003);
    checkOutput("t5_drain3", entryAt(0, 3), 10'h004);
    checkOutput("t5_empty", if0.rx_dv, 0);

    $display("[TB] break");
    clearMonitors();
    line0 = 1'b0;
    repeat (11 * CPB) @(negedge clk);
    line0 = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t6_break_once", brkCount0, 1);
    checkOutput("t6_no_push", q0.size(), 0);
    checkOutput("t6_idle", busy0, 0);
    applyStimulus(0, 8'h69, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t6_after_break", entryAt(0, 0), 10'h069);

    $display("[TB] reset mid-frame");
    clearMonitors();
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b0);
    driveBit(0, 1'b1);
    driveBit(0, 1'b1);
    line0 = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    checkOutput("t6_busy_mid_frame", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("t6_reset_outputs",
                {if0.rx_dv, if0.rx_data_out, if0.rx_frame_err, if0.rx_parity_err, ovr0, brk0, busy0}, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    applyStimulus(0, 8'hF0, 1'b0, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("t6_post_reset_count", q0.size(), 1);
    checkOutput("t6_post_reset_entry", entryAt(0, 0), 10'h0F0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Oversampling UART receiver. It is the receiving end for the existing UART_TX serial stream, with glitch rejection, optional parity, framing-error and break detection, and a small receive FIFO. It sits between the board-level RX pin and the byte consumer, which drains it through a valid/ready handshake. Frame format is 1 start bit, 8 data bits LSB first, an optional parity bit, and 1 stop bit.

Parameters:
cpb, 217, clocks per bit (25 MHz / 115200); must be at least 8.
parity_en, 0, 1 means a parity bit follows the data bits.
parity_odd, 0, 1 means odd parity and 0 means even; ignored when parity_en=0.
fifo_depth, 4, number of receive FIFO entries; must be a power of 2 and at least 2.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
rx_data_in  input  1  asynchronous serial line; idle level is high.
rx_data_out  output  8  byte at the FIFO head.
rx_dv  output  1  FIFO not empty; rx_data_out and the error flags are valid.
rx_ready  input  1  consumer accepts the head entry when rx_dv&&rx_ready.
rx_frame_err  output  1  head entry had a bad stop bit.
rx_parity_err  output  1  head entry had a parity mismatch; always 0 when parity_en=0.
rx_overrun  output  1  one-clock pulse when a completed byte is dropped because the FIFO is full.
rx_break  output  1  one-clock pulse when a break condition is detected.
rx_busy  output  1  high when the FSM is not in IDLE.

Behaviour:
- Input path
  - rx_data_in passes through a 2-flop synchronizer; both flops reset to 1.
  - The bit counter counts 0..cpb-1 within each bit period.
- Sampling
  - Each bit is sampled at counts cpb/2-1, cpb/2 and cpb/2+1.
  - The bit value is the 2-of-3 majority of those samples.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
  - IDLE: on a synchronized falling edge (1→0), clear the counter and go to START.
  - START: at the majority point, a majority 1 is a glitch; return to IDLE with no output. A majority 0 continues; at count cpb-1 go to DATA.
  - DATA: shift the majority bit in LSB first. After bit 7's period, go to PARITY if parity_en, else STOP.
  - PARITY: compute the expected parity over the 8 data bits (XOR of data ^ parity_odd). A mismatch sets the parity_err flag for this frame.
  - STOP, evaluated at the majority point (cpb/2+1):
    - Majority 1: push {parity_err, 0, byte}; return to IDLE immediately, without waiting out the rest of the stop bit.
    - Majority 0, data==0 and parity bit (if present) ==0: break. Pulse rx_break, push nothing, go to WAIT_IDLE.
    - Majority 0 otherwise: push {parity_err, 1, byte}, then go to WAIT_IDLE.
  - WAIT_IDLE: stay until the synchronized line is 1, then go to IDLE.
- FIFO
  - Registered, fifo_depth entries, each 10 bits: {parity_err, frame_err, data}.
  - A push makes rx_dv=1 on the following clock.
  - Pop happens when rx_dv&&rx_ready; the next entry appears on the next clock.
  - Full and push without pop: the byte is dropped and rx_overrun pulses for 1 clock. The FIFO contents are unchanged.
  - Full with push and pop in the same clock: both occur; no overrun.
  - Empty with rx_ready high: no effect.
  - Output data and flags are don't-care when rx_dv=0. Implementation drives the head register, which resets to 0.
  - Pointers wrap modulo fifo_depth. A count register of width $clog2(fifo_depth)+1 provides full/empty.
- Latency: from the stop-bit majority sample to rx_dv rising is 1 clock when the FIFO is empty.
- Reset (any time, including mid-frame)
  - FSM goes to IDLE, counters to 0, FIFO empty.
  - rx_dv=0, rx_data_out=0, all flags 0, rx_busy=0.
  - A frame in progress is discarded. A line still low after reset does not start a frame until a 1→0 edge is seen.

Decomposition:
- Package / include file uart_pkg holds:
  - FSM state encodings.
  - Default CLKS_PER_BIT.
  - FIFO entry field positions: PE_BIT=9, FE_BIT=8, data 7:0.
- One natural sub-module, sync_fifo: parameterised width/depth, push/pop/full/empty/count. It is reusable for the TX side later.

Test Plan:
1. Defaults; the bench sends 0x69 with rx_ready=1. Required: rx_dv pulses 1 clk with rx_data_out=0x69, rx_frame_err=0, rx_parity_err=0.
2. parity_en=1, parity_odd=1; send 0xA5 with parity=1, then 0xA5 with parity=0. Required: first entry has pe=0, second has pe=1; both have data 0xA5.
3. A 60-clk low glitch on an idle line. Required: no rx_dv, rx_busy returns to 0 within cpb clocks, and a following 0x3C frame is received correctly.
4. Send 0x3C with the stop bit held low for 1 bit time. Required: entry 0x3C with rx_frame_err=1. The FSM stays in WAIT_IDLE until the line rises, then 0x55 is received cleanly.
5. rx_ready=0; send 0x01..0x05. Required: rx_overrun pulses once, on the 5th byte. With rx_ready=1, the drain order is 0x01,0x02,0x03,0x04 and then rx_dv=0.
6. Line held low for 11 bit times. Required: rx_break pulses once, no FIFO push, and 0x69 is received afterwards. Separately, assert rst at data bit 4. Required: all outputs 0 next clock, and the next frame 0xF0 is received correctly.
